// File: rtl/ddr_pkg.sv
// Shared encodings for the DDR line mover: command opcodes and FSM states.
package ddr_pkg;

    typedef enum logic [1:0] {
        OpLoadSd    = 2'd0,
        OpWriteback = 2'd1,
        OpFill      = 2'd2,
        OpToCache   = 2'd3
    } cmd_op_e;

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StLoad   = 4'd1,
        StWrBeat = 4'd2,
        StRdReq  = 4'd3,
        StRdBeat = 4'd4,
        StPush   = 4'd5,
        StDone   = 4'd6
    } state_e;

endpackage

// File: rtl/line_beat_slicer.sv
// Indexed beat-wide read and write port on a full-line register value.
module line_beat_slicer #(
    parameter int unsigned LINE_W = 4096,
    parameter int unsigned BEAT_W = 128,
    parameter int unsigned IDX_W  = $clog2(LINE_W / BEAT_W)
) (
    input  logic [LINE_W-1:0] line,
    input  logic [IDX_W-1:0]  idx,
    input  logic              wr_en,
    input  logic [BEAT_W-1:0] wr_beat,
    output logic [BEAT_W-1:0] rd_beat,
    output logic [LINE_W-1:0] line_next
);

    localparam int unsigned BEATS = LINE_W / BEAT_W;

    always_comb begin
        rd_beat   = '0;
        line_next = line;
        for (int unsigned i = 0; i < BEATS; i++) begin
            if (idx == IDX_W'(i)) begin
                rd_beat = line[i*BEAT_W +: BEAT_W];
                if (wr_en) begin
                    line_next[i*BEAT_W +: BEAT_W] = wr_beat;
                end
            end
        end
    end

endmodule

// File: rtl/ddr_line_mover.sv
// Single-line transfer engine between SD loader, DDR beat port and cache,
// with per-beat timeout and a 4-phase cmd/done handshake.
module ddr_line_mover
    import ddr_pkg::*;
#(
    parameter int unsigned LINE_W  = 4096,
    parameter int unsigned BEAT_W  = 128,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              cmd_ready,
    output logic              done,
    output logic              err,
    input  logic [LINE_W-1:0] sd_data,
    output logic [LINE_W-1:0] cache_data,
    output logic [ADDR_W-1:0] ddr_addr,
    output logic              ddr_wr_valid,
    output logic [BEAT_W-1:0] ddr_wr_data,
    output logic              ddr_wr_last,
    input  logic              ddr_wr_ready,
    output logic              ddr_rd_req,
    input  logic              ddr_rd_valid,
    input  logic [BEAT_W-1:0] ddr_rd_data,
    output logic [3:0]        state
);

    localparam int unsigned BEATS = LINE_W / BEAT_W;
    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [TO_W-1:0]  TO_ABORT  = TO_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [LINE_W-1:0]  cache_q, cache_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               err_q, err_d;
    logic               slice_wr;
    logic [BEAT_W-1:0]  beat_rd;
    logic [LINE_W-1:0]  line_wr;

    line_beat_slicer #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W),
        .IDX_W  (CNT_W)
    ) u_slicer (
        .line      (line_q),
        .idx       (beat_cnt_q),
        .wr_en     (slice_wr),
        .wr_beat   (ddr_rd_data),
        .rd_beat   (beat_rd),
        .line_next (line_wr)
    );

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        cache_d    = cache_q;
        addr_d     = addr_q;
        beat_cnt_d = beat_cnt_q;
        to_cnt_d   = to_cnt_q;
        err_d      = err_q;
        slice_wr   = 1'b0;

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    err_d  = 1'b0;
                    case (cmd_op_e'(cmd_op))
                        OpLoadSd:    state_d = StLoad;
                        OpWriteback: state_d = StWrBeat;
                        OpFill:      state_d = StRdReq;
                        default:     state_d = StPush;
                    endcase
                end
            end
            StLoad: begin
                line_d  = sd_data;
                state_d = StDone;
            end
            StWrBeat: begin
                // A transferred beat always beats a coincident timeout.
                if (ddr_wr_ready) begin
                    to_cnt_d = '0;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = StDone;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (to_cnt_q == TO_ABORT) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StRdReq: begin
                state_d = StRdBeat;
            end
            StRdBeat: begin
                if (ddr_rd_valid) begin
                    slice_wr = 1'b1;
                    line_d   = line_wr;
                    to_cnt_d = '0;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = StDone;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (to_cnt_q == TO_ABORT) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StPush: begin
                cache_d = line_q;
                state_d = StDone;
            end
            StDone: begin
                if (!cmd_valid) begin
                    state_d    = StIdle;
                    beat_cnt_d = '0;
                    to_cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            line_q     <= '0;
            cache_q    <= '0;
            addr_q     <= '0;
            beat_cnt_q <= '0;
            to_cnt_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            cache_q    <= cache_d;
            addr_q     <= addr_d;
            beat_cnt_q <= beat_cnt_d;
            to_cnt_q   <= to_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        cmd_ready    = (state_q == StIdle);
        done         = (state_q == StDone);
        err          = done & err_q;
        ddr_wr_valid = (state_q == StWrBeat);
        ddr_wr_data  = ddr_wr_valid ? beat_rd : '0;
        ddr_wr_last  = ddr_wr_valid && (beat_cnt_q == LAST_BEAT);
        ddr_rd_req   = (state_q == StRdReq);
        ddr_addr     = addr_q;
        cache_data   = cache_q;
        state        = state_q;
    end

endmodule

// File: tb/tb_ddr_line_mover.sv
// Self-checking bench for ddr_line_mover: vector table, corner sequences and a
// randomized command stream checked against a line/cache model.
module tb_ddr_line_mover;
    import ddr_pkg::*;

    localparam int unsigned LW    = 256;
    localparam int unsigned BW    = 32;
    localparam int unsigned AW    = 16;
    localparam int unsigned TO    = 12;
    localparam int unsigned BEATS = LW / BW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic          cmd_ready, done, err;
    logic [LW-1:0] sd_data, cache_data;
    logic [AW-1:0] ddr_addr;
    logic          ddr_wr_valid, ddr_wr_last, ddr_wr_ready;
    logic [BW-1:0] ddr_wr_data;
    logic          ddr_rd_req, ddr_rd_valid;
    logic [BW-1:0] ddr_rd_data;
    logic [3:0]    state;

    ddr_line_mover #(
        .LINE_W  (LW),
        .BEAT_W  (BW),
        .ADDR_W  (AW),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_op       (cmd_op),
        .cmd_addr     (cmd_addr),
        .cmd_ready    (cmd_ready),
        .done         (done),
        .err          (err),
        .sd_data      (sd_data),
        .cache_data   (cache_data),
        .ddr_addr     (ddr_addr),
        .ddr_wr_valid (ddr_wr_valid),
        .ddr_wr_data  (ddr_wr_data),
        .ddr_wr_last  (ddr_wr_last),
        .ddr_wr_ready (ddr_wr_ready),
        .ddr_rd_req   (ddr_rd_req),
        .ddr_rd_valid (ddr_rd_valid),
        .ddr_rd_data  (ddr_rd_data),
        .state        (state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: the engine's held line and the last line pushed to the cache.
    logic [LW-1:0] m_line = '0;
    logic [LW-1:0] m_cache = '0;

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [LW-1:0] payload;
        int            mode;
        int            exp_lat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit pick(input int mode, input int opp, input int gap);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (opp % 2) == 0;
        if (gap >= 4) return 1'b1;
        return bit'($urandom_range(0, 1));
    endfunction

    // Issue one command, serve the DDR side, check results against the model.
    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [LW-1:0] payload, input int mode, input int exp_lat);
        int cyc = 0, nbeat = 0, opp = 0, gap = 0, reqs = 0;
        bit rd_on = 0, req_now, stalled = 0, rdy, vld;
        logic [BW-1:0] prev_data = '0;
        logic prev_last = 1'b0;
        check("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        sd_data   = payload;
        while (!done && cyc < 300) begin
            ddr_wr_ready = 1'b0;
            ddr_rd_valid = 1'b0;
            ddr_rd_data  = BW'($urandom);
            req_now = ddr_rd_req;
            if (req_now) reqs++;
            if (ddr_wr_valid) begin
                if (stalled) begin
                    check("wb_stall_data", ddr_wr_data, prev_data);
                    check("wb_stall_last", ddr_wr_last, prev_last);
                end
                rdy = pick(mode, opp, gap);
                opp++;
                ddr_wr_ready = rdy;
                if (rdy) begin
                    check("wb_data", ddr_wr_data, m_line[nbeat*BW +: BW]);
                    check("wb_last", ddr_wr_last, nbeat == BEATS - 1);
                    nbeat++;
                    gap = 0;
                end else begin
                    gap++;
                end
                stalled   = !rdy;
                prev_data = ddr_wr_data;
                prev_last = ddr_wr_last;
            end
            if (rd_on && nbeat < BEATS) begin
                vld = pick(mode, opp, gap);
                opp++;
                if (vld) begin
                    ddr_rd_valid = 1'b1;
                    ddr_rd_data  = payload[nbeat*BW +: BW];
                    nbeat++;
                    gap = 0;
                end else begin
                    gap++;
                end
            end
            tick();
            cyc++;
            if (req_now) rd_on = 1;
        end
        ddr_wr_ready = 1'b0;
        ddr_rd_valid = 1'b0;
        check("done_seen", done, 1'b1);
        check("done_err", err, 1'b0);
        check("ddr_addr", ddr_addr, addr);
        if (exp_lat >= 0) check("latency", cyc, exp_lat);
        case (op)
            OpLoadSd: m_line = payload;
            OpFill: begin
                m_line = payload;
                check("fill_req_pulses", reqs, 1);
                check("fill_beats", nbeat, BEATS);
            end
            OpWriteback: check("wb_beats", nbeat, BEATS);
            default: m_cache = m_line;
        endcase
        check("cache_data", cache_data, m_cache);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("done_held", done, 1'b1);
            check("no_accept_in_done", cmd_ready, 1'b0);
        end
        cmd_valid = 1'b0;
        tick();
        check("done_dropped", done, 1'b0);
        check("back_to_idle", cmd_ready, 1'b1);
    endtask

    initial begin
        logic [LW-1:0] pat_a, pat_i, rnd, part;
        int n;
        bit beat_now;
        for (int i = 0; i < BEATS; i++) begin
            pat_a[i*BW +: BW] = 32'hA5C3_0000 + 32'(i * 32'h111);
            pat_i[i*BW +: BW] = 32'(i);
        end
        reset_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_addr = '0;
        sd_data = '0;
        ddr_wr_ready = 1'b0;
        ddr_rd_valid = 1'b0;
        ddr_rd_data = '0;
        #23;
        check("rst_state", state, 4'd0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_cache", cache_data, '0);
        check("rst_addr", ddr_addr, '0);
        check("rst_wr_valid", ddr_wr_valid, 1'b0);
        check("rst_rd_req", ddr_rd_req, 1'b0);
        reset_n = 1'b1;
        tick();

        vecs[0] = '{OpLoadSd,    16'h0010, pat_a, 0, 2};
        vecs[1] = '{OpToCache,   16'h0011, '0,    0, 2};
        vecs[2] = '{OpWriteback, 16'h0020, '0,    1, -1};
        vecs[3] = '{OpFill,      16'h0040, pat_i, 0, -1};
        vecs[4] = '{OpToCache,   16'h0041, '0,    0, 2};
        vecs[5] = '{OpWriteback, 16'h0022, '0,    2, -1};
        vecs[6] = '{OpFill,      16'h0044, pat_a, 1, -1};
        for (int v = 0; v < 7; v++) begin
            run_cmd(vecs[v].op, vecs[v].addr, vecs[v].payload, vecs[v].mode, vecs[v].exp_lat);
        end

        // Partial fill: three beats then silence must time out.
        for (int i = 0; i < BEATS; i++) part[i*BW +: BW] = 32'hC0DE_0000 + 32'(i);
        cmd_valid = 1'b1;
        cmd_op = OpFill;
        cmd_addr = 16'h0050;
        tick();
        check("to_rd_req", ddr_rd_req, 1'b1);
        tick();
        check("to_rd_req_pulse", ddr_rd_req, 1'b0);
        for (int i = 0; i < 3; i++) begin
            ddr_rd_valid = 1'b1;
            ddr_rd_data = part[i*BW +: BW];
            m_line[i*BW +: BW] = part[i*BW +: BW];
            tick();
        end
        ddr_rd_valid = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, TO);
        check("timeout_err", err, 1'b1);
        cmd_valid = 1'b0;
        tick();
        run_cmd(OpToCache, 16'h0051, '0, 0, 2);

        // Reset while beat 5 of a writeback is being offered.
        run_cmd(OpLoadSd, 16'h0060, pat_a, 0, 2);
        cmd_valid = 1'b1;
        cmd_op = OpWriteback;
        cmd_addr = 16'h0061;
        n = 0;
        for (int c = 0; c < 50 && n < 5; c++) begin
            beat_now = ddr_wr_valid;
            ddr_wr_ready = 1'b1;
            tick();
            if (beat_now) n++;
        end
        ddr_wr_ready = 1'b0;
        check("rst_at_beat5_data", ddr_wr_data, m_line[5*BW +: BW]);
        reset_n = 1'b0;
        #1;
        check("rst_mid_state", state, 4'd0);
        check("rst_mid_ready", cmd_ready, 1'b1);
        check("rst_mid_wr_valid", ddr_wr_valid, 1'b0);
        cmd_valid = 1'b0;
        tick();
        check("rst_mid_no_done", done, 1'b0);
        reset_n = 1'b1;
        m_line = '0;
        m_cache = '0;
        tick();
        tick();
        check("rst_mid_still_no_done", done, 1'b0);
        run_cmd(OpToCache, 16'h0062, '0, 0, 2);

        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < BEATS; i++) rnd[i*BW +: BW] = BW'($urandom);
            run_cmd(2'($urandom_range(0, 3)), AW'($urandom), rnd, 2, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
